aemb_intc: RTL and testbench

Wishbone-slave interrupt controller upstream of the system control unit. Collects NIRQ external interrupt sources and drives the core's single sys_int_i line through sys_int_o. The system control unit latches only on rising edges, so this block re-arms its output (forced low gap) whenever software services one source while others remain pending. Software can read a priority-encoded vector.

---
 rtl/aemb_intc.sv | 148 ++++++++++++++
 tb/tb_aemb_intc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_intc.sv
// Wishbone interrupt controller feeding the core's edge-sensitive sys_int_i.
// Define AEMB_INTC_SYNC_EN to add a 2-flop synchroniser on irq_i for asynchronous sources.
module aemb_intc #(
  parameter int          NIRQ  = 8,
  parameter logic [31:0] EDGE  = 32'h0000_00FF,
  parameter int          REARM = 2
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  input  logic [NIRQ-1:0] irq_i,
  output logic            sys_int_o
);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  logic [NIRQ-1:0] s, pReg, isrReg, isrNext, ierReg, ierNext;
  logic            merReg, merNext;
  logic            ackReg, sysIntReg;
  logic [31:0]     datReg, rdData, ivr;
  logic [3:0]      cntReg;
  state_t          stateReg;
  logic            acc, wrIsr, wrIer, wrMer, active, activeNext;
  logic            unusedBits;

`ifdef AEMB_INTC_SYNC_EN
  logic [NIRQ-1:0] sync1Reg, sync2Reg;
  always_ff @(posedge gclk) begin
    if (grst) begin
      sync1Reg <= '0;
      sync2Reg <= '0;
    end else begin
      sync1Reg <= irq_i;
      sync2Reg <= sync1Reg;
    end
  end
  assign s = sync2Reg;
`else
  // Sources are already gclk-synchronous; the ISR register is the only stage.
  assign s = irq_i;
`endif

  // The access that sets ack is the one that commits.
  assign acc   = wb_stb_i & ~ackReg;
  assign wrIsr = acc & wb_we_i & (wb_adr_i == 2'd0);
  assign wrIer = acc & wb_we_i & (wb_adr_i == 2'd1);
  assign wrMer = acc & wb_we_i & (wb_adr_i == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NIRQ; gi++) begin : g_isr
      if (EDGE[gi]) begin : g_edge
        // A new edge beats a simultaneous W1C.
        assign isrNext[gi] = (s[gi] & ~pReg[gi]) | (isrReg[gi] & ~(wrIsr & wb_dat_i[gi]));
      end else begin : g_level
        assign isrNext[gi] = s[gi];
      end
    end
  endgenerate

  assign ierNext    = wrIer ? wb_dat_i[NIRQ-1:0] : ierReg;
  assign merNext    = wrMer ? wb_dat_i[0] : merReg;
  assign active     = merReg & (|(isrReg & ierReg));
  assign activeNext = merNext & (|(isrNext & ierNext));
  assign unusedBits = &{1'b0, wb_dat_i};

  always_comb begin
    ivr = 32'hFFFF_FFFF;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (isrReg[i] & ierReg[i]) ivr = 32'(i);
    end
  end

  always_comb begin
    rdData = '0;
    case (wb_adr_i)
      2'd0:    rdData[NIRQ-1:0] = isrReg;
      2'd1:    rdData[NIRQ-1:0] = ierReg;
      2'd2:    rdData = ivr;
      default: rdData[0] = merReg;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      pReg   <= '0;
      isrReg <= '0;
      ierReg <= '0;
      merReg <= 1'b0;
      ackReg <= 1'b0;
      datReg <= '0;
    end else begin
      pReg   <= s;
      isrReg <= isrNext;
      ierReg <= ierNext;
      merReg <= merNext;
      ackReg <= acc;
      if (acc) datReg <= rdData;
    end
  end

  // Output FSM: servicing one source while others remain forces a low gap
  // so the downstream unit sees a fresh rising edge.
  always_ff @(posedge gclk) begin
    if (grst) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      sysIntReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (active) begin
            stateReg  <= ASSERT;
            sysIntReg <= 1'b1;
          end
        end
        ASSERT: begin
          if ((wrIsr | wrIer) & activeNext) begin
            stateReg  <= GAP;
            cntReg    <= 4'(REARM);
            sysIntReg <= 1'b0;
          end else if (!active) begin
            stateReg  <= IDLE;
            sysIntReg <= 1'b0;
          end
        end
        GAP: begin
          if (cntReg <= 4'd1) stateReg <= IDLE;
          else                cntReg   <= cntReg - 4'd1;
        end
        default: begin
          stateReg  <= IDLE;
          sysIntReg <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o  = ackReg;
  assign wb_dat_o  = datReg;
  assign sys_int_o = sysIntReg;

endmodule

// File: tb/tb_aemb_intc.sv
// Directed bench for aemb_intc: an all-edge instance and a bit0-level instance share stimulus.
module tb_aemb_intc;

`ifdef AEMB_INTC_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam int REARM = 2;

  logic        gclk = 1'b0;
  logic        grst;
  logic        wbStb, wbWe;
  logic [1:0]  wbAdr;
  logic [31:0] wbDat;
  logic [7:0]  irq;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, int0, int1;
  int          vecs = 0;
  int          errs = 0;

  always #5 gclk = ~gclk;

  aemb_intc #(.NIRQ(8), .EDGE(32'hFF), .REARM(REARM)) u_dut (
    .gclk(gclk), .grst(grst), .wb_stb_i(wbStb), .wb_we_i(wbWe), .wb_adr_i(wbAdr),
    .wb_dat_i(wbDat), .wb_dat_o(dat0), .wb_ack_o(ack0), .irq_i(irq), .sys_int_o(int0));

  aemb_intc #(.NIRQ(8), .EDGE(32'hFE), .REARM(REARM)) u_lvl (
    .gclk(gclk), .grst(grst), .wb_stb_i(wbStb), .wb_we_i(wbWe), .wb_adr_i(wbAdr),
    .wb_dat_i(wbDat), .wb_dat_o(dat1), .wb_ack_o(ack1), .irq_i(irq), .sys_int_o(int1));

  task automatic doReset();
    grst = 1'b1; wbStb = 1'b0; wbWe = 1'b0; wbAdr = 2'd0; wbDat = '0; irq = '0;
    repeat (2) @(negedge gclk);
    grst = 1'b0;
    @(negedge gclk);
  endtask

  // Called at a negedge; commit happens on the next posedge; returns two negedges later.
  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    wbStb = 1'b1; wbWe = 1'b1; wbAdr = a; wbDat = d;
    @(posedge gclk);
    @(negedge gclk);
    wbStb = 1'b0; wbWe = 1'b0;
    @(negedge gclk);
  endtask

  task automatic busRead(input logic [1:0] a, input int which, output logic [31:0] d);
    wbStb = 1'b1; wbWe = 1'b0; wbAdr = a;
    @(posedge gclk);
    @(negedge gclk);
    d = (which != 0) ? dat1 : dat0;
    wbStb = 1'b0;
    @(negedge gclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq = bits;
    @(negedge gclk);
    irq = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    doReset();
    chk("reset ack", {31'b0, ack0}, 32'd0);
    chk("reset int", {31'b0, int0}, 32'd0);
    chk("reset dat", dat0, 32'd0);
    busRead(2'd0, 0, d); chk("reset ISR", d, 32'd0);
    busRead(2'd1, 0, d); chk("reset IER", d, 32'd0);
    busRead(2'd3, 0, d); chk("reset MER", d, 32'd0);
    busRead(2'd2, 0, d); chk("reset IVR", d, 32'hFFFF_FFFF);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [3:0]  acks;
    busWrite(2'd1, 32'hFFFF_FFFF); busRead(2'd1, 0, d); chk("IER upper bits", d, 32'h0000_00FF);
    busWrite(2'd3, 32'hFFFF_FFFF); busRead(2'd3, 0, d); chk("MER upper bits", d, 32'h0000_0001);
    busWrite(2'd1, 32'h0); busWrite(2'd3, 32'h0);
    busRead(2'd1, 0, d); chk("IER cleared", d, 32'd0);
    // Held strobe: ack every other cycle.
    wbStb = 1'b1; wbWe = 1'b0; wbAdr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge gclk);
      acks[i] = ack0;
    end
    wbStb = 1'b0;
    @(negedge gclk);
    chk("held strobe ack pattern", {28'b0, acks}, 32'h5);
  endtask

  task automatic test_edge_single();
    logic [31:0] d;
    doReset();
    busWrite(2'd3, 32'h1);
    busWrite(2'd1, 32'h01);
    irq = 8'h01;
    @(negedge gclk);
    irq = '0;
    repeat (L - 1) @(negedge gclk);
    chk("t1 int before", {31'b0, int0}, 32'd0);
    @(negedge gclk);
    chk("t1 int asserted", {31'b0, int0}, 32'd1);
    busRead(2'd0, 0, d); chk("t1 ISR", d, 32'h1);
    busRead(2'd2, 0, d); chk("t1 IVR", d, 32'd0);
  endtask

  task automatic test_rearm();
    logic [31:0] d;
    logic [4:0]  seen;
    busWrite(2'd0, 32'h1);
    busWrite(2'd1, 32'h06);
    pulse(8'h06);
    repeat (L + 2) @(negedge gclk);
    chk("t2 int high", {31'b0, int0}, 32'd1);
    busRead(2'd2, 0, d); chk("t2 IVR=1", d, 32'd1);
    // Service bit1 while bit2 pending: low for REARM+1 cycles, then high.
    wbStb = 1'b1; wbWe = 1'b1; wbAdr = 2'd0; wbDat = 32'h2;
    @(posedge gclk);
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      seen[i] = int0;
      wbStb = 1'b0; wbWe = 1'b0;
    end
    chk("t2 gap pattern", {27'b0, seen}, 32'h18);
    busRead(2'd2, 0, d); chk("t2 IVR=2", d, 32'd2);
    busWrite(2'd0, 32'h4);
    repeat (4) @(negedge gclk);
    chk("t2 int dropped", {31'b0, int0}, 32'd0);
    busRead(2'd0, 0, d); chk("t2 ISR empty", d, 32'd0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    doReset();
    busWrite(2'd3, 32'h1);
    busWrite(2'd1, 32'h1);
    irq = 8'h01;
    repeat (L + 2) @(negedge gclk);
    chk("t3 level int", {31'b0, int1}, 32'd1);
    busWrite(2'd0, 32'h1);
    repeat (REARM + 3) @(negedge gclk);
    chk("t3 int after W1C", {31'b0, int1}, 32'd1);
    busRead(2'd0, 1, d); chk("t3 ISR level kept", d, 32'h1);
    irq = '0;
    repeat (L) @(negedge gclk);
    chk("t3 int still high", {31'b0, int1}, 32'd1);
    @(negedge gclk);
    chk("t3 int low L+1", {31'b0, int1}, 32'd0);
  endtask

  task automatic test_set_vs_w1c();
    logic [31:0] d;
    doReset();
    irq = 8'h08;
    repeat (L - 1) @(negedge gclk);
    busWrite(2'd0, 32'h8);
    busRead(2'd0, 0, d); chk("t4 set beats W1C", d, 32'h8);
    busWrite(2'd0, 32'h8);
    busRead(2'd0, 0, d); chk("t4 W1C clears", d, 32'h0);
    irq = '0;
  endtask

  task automatic test_mask();
    logic [31:0] d;
    doReset();
    busWrite(2'd3, 32'h1);
    pulse(8'h10);
    repeat (L + 2) @(negedge gclk);
    chk("t5 masked int", {31'b0, int0}, 32'd0);
    busRead(2'd2, 0, d); chk("t5 IVR none", d, 32'hFFFF_FFFF);
    busRead(2'd0, 0, d); chk("t5 ISR kept", d, 32'h10);
    wbStb = 1'b1; wbWe = 1'b1; wbAdr = 2'd1; wbDat = 32'h10;
    @(posedge gclk);
    @(negedge gclk);
    wbStb = 1'b0; wbWe = 1'b0;
    chk("t5 int at commit", {31'b0, int0}, 32'd0);
    @(negedge gclk);
    chk("t5 int unmasked", {31'b0, int0}, 32'd1);
    busRead(2'd2, 0, d); chk("t5 IVR=4", d, 32'd4);
  endtask

  task automatic test_reset_midcycle();
    logic [31:0] d;
    grst = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbAdr = 2'd1; wbDat = 32'hFF;
    @(posedge gclk);
    @(negedge gclk);
    chk("t6 int", {31'b0, int0}, 32'd0);
    chk("t6 ack", {31'b0, ack0}, 32'd0);
    grst = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
    @(negedge gclk);
    busRead(2'd0, 0, d); chk("t6 ISR", d, 32'd0);
    busRead(2'd1, 0, d); chk("t6 IER", d, 32'd0);
    busRead(2'd3, 0, d); chk("t6 MER", d, 32'd0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge_single();
    test_rearm();
    test_level();
    test_set_vs_w1c();
    test_mask();
    test_reset_midcycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
